// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - parametrised Fibonacci LFSR with a bounded mask-and-reject range request port
module lfsr_rng #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int               OUT_W     = 8,
    parameter int               MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OUT_W-1:0] req_limit,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_value,
    output logic [WIDTH-1:0] q
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        RESP
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] limit_r;
    logic [OUT_W-1:0] mask_r;
    logic [TRY_W-1:0] tries;

    logic             fb;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] seed_val;
    logic [OUT_W-1:0] cand;
    logic             advance;

    // Smear every set bit downward: yields the smallest 2^k-1 covering v.
    function automatic logic [OUT_W-1:0] cover_mask(input logic [OUT_W-1:0] v);
        logic [OUT_W-1:0] m;
        m = v;
        for (int i = 1; i < OUT_W; i++) begin
            m = m | (v >> i);
        end
        return m;
    endfunction

    always_comb begin
        fb       = ^(q & TAPS);
        q_step   = {q[WIDTH-2:0], fb};
        seed_val = (seed_in == '0) ? SEED : seed_in;
        cand     = q[OUT_W-1:0] & mask_r;
        advance  = en | (state == DRAW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= SEED;
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_value <= '0;
            tries     <= '0;
            limit_r   <= '0;
            mask_r    <= '0;
        end else begin
            // Load beats advance; a DRAW candidate always sees the pre-edge q.
            if (seed_load) begin
                q <= seed_val;
            end else if (advance) begin
                q <= q_step;
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        limit_r   <= req_limit;
                        mask_r    <= cover_mask(req_limit);
                        tries     <= '0;
                        state     <= DRAW;
                        req_ready <= 1'b0;
                    end
                end
                DRAW: begin
                    if (cand <= limit_r) begin
                        rsp_value <= cand;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (tries == LAST_TRY) begin
                        // cand is below 2*limit+2 here, so halving lands inside the range.
                        rsp_value <= cand >> 1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        tries <= tries + TRY_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - scoreboard bench for lfsr_rng (8-bit config, plus a MAX_TRIES=1 instance)
module tb_lfsr_rng;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic [7:0] req_limit = 8'h00;
    logic       req_valid = 1'b0;
    logic       rsp_ready = 1'b0;
    logic       req_valid2 = 1'b0;
    logic       rsp_ready2 = 1'b0;

    logic       req_ready, rsp_valid, req_ready2, rsp_valid2;
    logic [7:0] rsp_value, rsp_value2, q, q2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] value;
        int         lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lfsr_rng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hDA), .OUT_W(8), .MAX_TRIES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_limit(req_limit),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_value(rsp_value), .q(q)
    );

    lfsr_rng #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hDA), .OUT_W(8), .MAX_TRIES(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_limit(req_limit),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_value(rsp_value2), .q(q2)
    );

    function automatic logic [7:0] model_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reseed();
        seed_in   = 8'hDA;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    // Latency counts edges from the accept edge (1) to the edge that raises rsp_valid.
    task automatic run_req(input bit use2, input logic [7:0] limit,
                           output logic [7:0] val, output int lat, output bit ok);
        req_limit = limit;
        if (use2) req_valid2 = 1'b1;
        else      req_valid  = 1'b1;
        lat = 0;
        ok  = 1'b0;
        val = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            req_valid  = 1'b0;
            req_valid2 = 1'b0;
            if (use2 ? rsp_valid2 : rsp_valid) begin
                ok  = 1'b1;
                val = use2 ? rsp_value2 : rsp_value;
                break;
            end
        end
    endtask

    task automatic check_rsp(input string name, input bit ok, input logic [7:0] val, input int lat);
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: no rsp_valid within 20 cycles, required latency %0d", name, e.lat);
        end
        checks++;
        if (val !== e.value) begin
            errors++;
            $display("FAIL %s_value: got %h required %h", name, val, e.value);
        end
        checks++;
        if (lat !== e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, e.lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (q !== 8'hDA) begin errors++; $display("FAIL reset_q: got %h required da", q); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_value !== 8'h00) begin errors++; $display("FAIL reset_rsp_value: got %h required 00", rsp_value); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_lfsr_run();
        logic [7:0] m;
        m  = 8'hDA;
        en = 1'b1;
        for (int s = 1; s <= 255; s++) begin
            tick();
            m = model_step(m);
            checks++;
            if (q !== m || q == 8'h00) begin
                errors++;
                $display("FAIL run_step%0d: got %h required %h", s, q, m);
            end
            if (s == 1) begin
                checks++; if (q !== 8'hB5) begin errors++; $display("FAIL run_first: got %h required b5", q); end
            end
            if (s == 2) begin
                checks++; if (q !== 8'h6B) begin errors++; $display("FAIL run_second: got %h required 6b", q); end
            end
        end
        checks++; if (q !== 8'hDA) begin errors++; $display("FAIL run_period: got %h required da", q); end
        en = 1'b0;
    endtask

    task automatic test_seed_load();
        seed_in   = 8'h3C;
        seed_load = 1'b1;
        en        = 1'b1;
        tick();
        checks++; if (q !== 8'h3C) begin errors++; $display("FAIL seed_load_wins: got %h required 3c", q); end
        en      = 1'b0;
        seed_in = 8'h00;
        tick();
        seed_load = 1'b0;
        checks++; if (q !== 8'hDA) begin errors++; $display("FAIL seed_zero: got %h required da", q); end
    endtask

    task automatic test_full_range();
        logic [7:0] v; int lat; bit ok;
        reseed();
        sb.push_back('{8'hDA, 2});
        run_req(1'b0, 8'hFF, v, lat, ok);
        check_rsp("full_range", ok, v, lat);
        checks++; if (q !== 8'hB5) begin errors++; $display("FAIL full_range_q: got %h required b5", q); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL full_range_release: got valid %b ready %b required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reject();
        logic [7:0] v; int lat; bit ok;
        reseed();
        sb.push_back('{8'h35, 3});
        run_req(1'b0, 8'h50, v, lat, ok);
        check_rsp("reject_once", ok, v, lat);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        sb.push_back('{8'h00, 2});
        run_req(1'b0, 8'h00, v, lat, ok);
        check_rsp("limit_zero", ok, v, lat);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_fallback();
        logic [7:0] v; int lat; bit ok;
        reseed();
        sb.push_back('{8'h2D, 2});
        run_req(1'b1, 8'h50, v, lat, ok);
        check_rsp("fallback", ok, v, lat);
        rsp_ready2 = 1'b1; tick(); rsp_ready2 = 1'b0;
        checks++; if (rsp_valid2 !== 1'b0) begin errors++; $display("FAIL fallback_release: got %b required 0", rsp_valid2); end
    endtask

    task automatic test_en_in_draw();
        logic [7:0] v; int lat; bit ok;
        reseed();
        en = 1'b1;
        sb.push_back('{8'h35, 2});
        run_req(1'b0, 8'h50, v, lat, ok);
        checks++; if (q !== 8'h6B) begin errors++; $display("FAIL en_draw_single_step: got %h required 6b", q); end
        en = 1'b0;
        check_rsp("en_in_draw", ok, v, lat);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v, m; int lat; bit ok;
        reseed();
        sb.push_back('{8'hDA, 2});
        run_req(1'b0, 8'hFF, v, lat, ok);
        check_rsp("hold_first", ok, v, lat);
        m         = q;
        en        = 1'b1;
        req_limit = 8'h10;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            m = model_step(m);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_value !== 8'hDA || req_ready !== 1'b0 || q !== m) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid %b value %h ready %b q %h required 1 da 0 %h",
                         i, rsp_valid, rsp_value, req_ready, q, m);
            end
        end
        req_valid = 1'b0;
        en        = 1'b0;
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: got valid %b ready %b required 0 1", rsp_valid, req_ready);
        end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_no_extra: got %b required 0", rsp_valid); end
    endtask

    task automatic test_rst_mid();
        bit seen;
        reseed();
        en = 1'b1; tick(); tick(); en = 1'b0;
        req_limit = 8'hFF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_draw: got ready %b required 0", req_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b required 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b required 0", rsp_valid); end
        checks++; if (q !== 8'hDA) begin errors++; $display("FAIL rst_mid_q: got %h required da", q); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_mid_discard: got rsp_valid 1 required 0"); end
    endtask

    initial begin
        test_reset();
        test_lfsr_run();
        test_seed_load();
        test_full_range();
        test_reject();
        test_fallback();
        test_en_in_draw();
        test_back_to_back();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised Fibonacci LFSR with a bounded random-number request port, replacing the fixed 8-bit LFSR.
- Width, tap mask and seed are parameters.
- Supports runtime seed load and zero-seed protection.
- A valid/ready request returns a value in [0, limit] by mask-and-reject sampling, with a bounded retry count.
- Feeds encounter, damage-roll and AI-choice logic that needs ranged randoms.

Parameters:
WIDTH, 16, LFSR state width (>= OUT_W, >= 2)
TAPS, 16'hB400, feedback tap mask; bit i set means state bit i is XORed into feedback
SEED, 16'hACE1, reset/fallback seed; must be nonzero
OUT_W, 8, width of request limit and response value
MAX_TRIES, 4, rejected draws allowed before fallback (>= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  free-run advance, one LFSR step per cycle
seed_load  in  1  load seed_in into the LFSR this cycle
seed_in  in  WIDTH  runtime seed
req_valid  in  1  range request valid
req_ready  out  1  high in IDLE only
req_limit  in  OUT_W  inclusive upper bound of requested value
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_value  out  OUT_W  random value in [0, limit]
q  out  WIDTH  current LFSR state

Behaviour:
Clock and reset:
- Single clock.
- Reset is synchronous, active-high. Its effect is visible after the rst-high edge.

Reset values:
- q=SEED, rsp_valid=0, rsp_value=0.
- FSM=IDLE, so req_ready=1.
- Retry counter=0.

LFSR step:
- fb = XOR of q[i] over all i with TAPS[i]=1.
- next q = {q[WIDTH-2:0], fb}.

Register priority for q:
- rst, then seed_load, then advance.
- advance = en OR (FSM==DRAW). At most one step per cycle.
- seed_load with seed_in==0 loads SEED instead, so q is never zero.

Mask:
- Latched at request accept: mask = smallest (2^k - 1) >= req_limit.
- limit=0 gives mask=0.
- limit is latched at the same time.

FSM states: IDLE, DRAW, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch limit and mask, clear tries, go to DRAW.
  - No FSM-driven advance in this cycle.
- DRAW:
  - cand = q[OUT_W-1:0] & mask, taken from the pre-advance q. q advances this cycle.
  - If cand <= limit: rsp_value <= cand, go to RESP.
  - Else if tries == MAX_TRIES-1: rsp_value <= cand >> 1 (always <= limit), go to RESP.
  - Else: tries++, stay in DRAW.
- RESP:
  - rsp_valid=1. rsp_value is held stable while rsp_ready=0.
  - On rsp_ready: go to IDLE, rsp_valid=0 next cycle.
  - No new request is accepted in the same cycle.

Latency:
- Request accepted at edge T gives rsp_valid at T+2 (first draw accepted).
- Each rejection adds 1 cycle.
- Worst case is T+1+MAX_TRIES.

Boundary conditions:
- en during DRAW: still one step per cycle, no double advance.
- en during IDLE/RESP steps q normally. rsp_value is unaffected.
- seed_load during DRAW: that cycle's candidate uses the pre-load q. The next draw uses the loaded seed. The FSM is not restarted.
- rst mid-operation: FSM returns to IDLE, rsp_valid drops, and the request is discarded.
- limit = 2^OUT_W - 1: mask is all ones and the first draw is always accepted.

Test Plan:
(All with WIDTH=8, TAPS=8'hB8, SEED=8'hDA, OUT_W=8, MAX_TRIES=4 unless noted.)
1. Reset, then en=1 for 2 cycles -> q=8'hB5, then 8'h6B. Run 255 total steps -> q==8'hDA again, and q never 0 on any cycle.
2. seed_load with seed_in=8'h00 -> q=8'hDA. seed_load with seed_in=8'h3C while en=1 -> q=8'h3C (load wins).
3. req_limit=8'hFF accepted at T, en=0 -> rsp_valid at T+2, rsp_value=8'hDA, q=8'hB5.
4. req_limit=8'h50 (mask 7F) -> cand 8'h5A rejected, then 8'h35 accepted. rsp_valid at T+3, rsp_value=8'h35. req_limit=0 -> rsp_value=0 at T+2.
5. MAX_TRIES=1, req_limit=8'h50 -> fallback rsp_value=8'h2D at T+2.
6. rsp_ready=0 for 5 cycles -> rsp_value is stable and req_ready=0. Asserting rst during DRAW -> IDLE next cycle, rsp_valid=0, q=8'hDA.
